// File: rtl/rr_grant_ctrl_pkg.sv
// Shared arbitration types and helpers for the round-robin grant controller.
package rr_grant_ctrl_pkg;

   typedef enum logic {
      RR_IDLE = 1'b0,
      RR_BUSY = 1'b1
   } rr_state_e;

   // Modulo-n increment. This must also be correct when n is not a power of two.
   function automatic int unsigned rr_next_ptr(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_grant_ctrl_pick.sv
// Combinational round-robin picker: the first set request scanning upward from ptr, with wrap.
module rr_pick
   import rr_grant_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] win,
   output logic [IDX_W-1:0]   win_idx,
   output logic               win_vld
);

   logic [2*NUM_REQ-1:0] dbl;
   logic                 found;

   // Replicate req to double width, mask out positions below ptr, then take the lowest set bit.
   always_comb begin
      dbl     = '0;
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      for (int j = 0; j < 2*NUM_REQ; j++) begin
         dbl[j] = req[j % NUM_REQ] & (j >= int'(ptr));
      end
      for (int j = 0; j < 2*NUM_REQ; j++) begin
         if (!found && dbl[j]) begin
            found                                         = 1'b1;
            win[(j >= NUM_REQ) ? (j - NUM_REQ) : j]       = 1'b1;
            win_idx = IDX_W'((j >= NUM_REQ) ? (j - NUM_REQ) : j);
         end
      end
      win_vld = found;
   end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Registered round-robin arbiter with grant hold until handshake and a lock for multi-beat transfers.
//
//   state   | meaning
//   --------+----------------------------------------------
//   RR_IDLE | no grant outstanding
//   RR_BUSY | gnt held until gnt_vld & gnt_rdy handshake
module rr_grant_ctrl
   import rr_grant_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               lock,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_vld,
   input  logic               gnt_rdy,
   output logic [IDX_W-1:0]   ptr
);

   rr_state_e            state, state_nxt;
   logic [NUM_REQ-1:0]   gnt_nxt;
   logic [IDX_W-1:0]     idx_nxt;
   logic [IDX_W-1:0]     ptr_nxt;
   logic [IDX_W-1:0]     ptr_adv;
   logic [NUM_REQ-1:0]   pick_req;
   logic [IDX_W-1:0]     pick_ptr;
   logic [NUM_REQ-1:0]   pick_gnt;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_vld;

   // The pointer advance and the owner mask only matter on a BUSY handshake, so one picker serves both states.
   assign ptr_adv  = IDX_W'(rr_next_ptr(32'(gnt_idx), NUM_REQ));
   assign pick_req = (state == RR_BUSY) ? (req & ~gnt) : req;
   assign pick_ptr = (state == RR_BUSY) ? ptr_adv : ptr;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req     (pick_req),
      .ptr     (pick_ptr),
      .win     (pick_gnt),
      .win_idx (pick_idx),
      .win_vld (pick_vld)
   );

   // State and output registers; reset clears every grant output immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RR_IDLE;
         gnt     <= '0;
         gnt_idx <= '0;
         gnt_vld <= 1'b0;
         ptr     <= '0;
      end else begin
         state   <= state_nxt;
         gnt     <= gnt_nxt;
         gnt_idx <= idx_nxt;
         gnt_vld <= |gnt_nxt;
         ptr     <= ptr_nxt;
      end
   end

   // Next-state and next-grant logic. The grant is frozen until a handshake.
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      idx_nxt   = gnt_idx;
      ptr_nxt   = ptr;
      case (state)
         RR_IDLE: begin
            if (pick_vld) begin
               state_nxt = RR_BUSY;
               gnt_nxt   = pick_gnt;
               idx_nxt   = pick_idx;
            end
         end
         RR_BUSY: begin
            if (gnt_rdy && !lock) begin
               ptr_nxt = ptr_adv;
               if (pick_vld) begin
                  gnt_nxt = pick_gnt;
                  idx_nxt = pick_idx;
               end else begin
                  state_nxt = RR_IDLE;
                  gnt_nxt   = '0;
                  idx_nxt   = '0;
               end
            end
         end
         default: begin
            state_nxt = RR_IDLE;
            gnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

`ifndef ASSERT_OFF
   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
   a_gnt_stable: assert property (@(posedge clk) disable iff (!rst_n)
                                  (gnt_vld && !gnt_rdy) |=> $stable(gnt));
   a_gnt_vld:    assert property (@(posedge clk) disable iff (!rst_n) gnt_vld == (|gnt));
`endif

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl: a four-requester instance plus a three-requester instance.
module tb_rr_grant_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       lock;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic       gnt_rdy;
   logic [1:0] ptr;

   logic [2:0] req3;
   logic       lock3;
   logic [2:0] gnt3;
   logic [1:0] gnt_idx3;
   logic       gnt_vld3;
   logic       gnt_rdy3;
   logic [1:0] ptr3;

   int errors = 0;
   int checks = 0;

   rr_grant_ctrl #(.NUM_REQ(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .lock    (lock),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .gnt_rdy (gnt_rdy),
      .ptr     (ptr)
   );

   rr_grant_ctrl #(.NUM_REQ(3)) dut3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req3),
      .lock    (lock3),
      .gnt     (gnt3),
      .gnt_idx (gnt_idx3),
      .gnt_vld (gnt_vld3),
      .gnt_rdy (gnt_rdy3),
      .ptr     (ptr3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Leaves the bench at a negedge with reset released and all inputs idle.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req = '0; lock = 1'b0; gnt_rdy = 1'b0;
      req3 = '0; lock3 = 1'b0; gnt_rdy3 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_idx !== 2'd0 || ptr !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: gnt=%b vld=%b idx=%0d ptr=%0d, want 0000 0 0 0", gnt, gnt_vld, gnt_idx, ptr);
      end
      do_reset();
      req = 4'b0000;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || ptr !== 2'd0) begin
         errors++;
         $display("FAIL idle_no_req: gnt=%b ptr=%0d, want 0000 0", gnt, ptr);
      end
      req = 4'b0100;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || gnt_vld !== 1'b1) begin
         errors++;
         $display("FAIL first_grant: gnt=%b idx=%0d vld=%b, want 0100 2 1", gnt, gnt_idx, gnt_vld);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [5];
      logic [1:0] exp_p [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_p = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      req = 4'b1111; gnt_rdy = 1'b1; lock = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (gnt !== exp_g[i] || ptr !== exp_p[i] || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL rr_seq[%0d]: gnt=%b ptr=%0d vld=%b, want %b %0d 1", i, gnt, ptr, gnt_vld, exp_g[i], exp_p[i]);
         end
      end
   endtask

   task automatic test_hold();
      do_reset();
      req = 4'b1111; gnt_rdy = 1'b0;
      @(negedge clk);
      gnt_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0010 || ptr !== 2'd1) begin
         errors++;
         $display("FAIL hold_setup: gnt=%b ptr=%0d, want 0010 1", gnt, ptr);
      end
      gnt_rdy = 1'b0;
      req = 4'b1101;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
            errors++;
            $display("FAIL hold_frozen[%0d]: gnt=%b idx=%0d, want 0010 1", i, gnt, gnt_idx);
         end
      end
      gnt_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0100 || ptr !== 2'd2) begin
         errors++;
         $display("FAIL hold_release: gnt=%b ptr=%0d, want 0100 2", gnt, ptr);
      end
   endtask

   task automatic test_lock();
      do_reset();
      req = 4'b1000; gnt_rdy = 1'b0;
      @(negedge clk);
      req = 4'b1001; lock = 1'b1; gnt_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (gnt !== 4'b1000 || ptr !== 2'd0) begin
            errors++;
            $display("FAIL lock_hold[%0d]: gnt=%b ptr=%0d, want 1000 0", i, gnt, ptr);
         end
      end
      lock = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || ptr !== 2'd0) begin
         errors++;
         $display("FAIL lock_wrap: gnt=%b idx=%0d ptr=%0d, want 0001 0 0", gnt, gnt_idx, ptr);
      end
   endtask

   task automatic test_three();
      logic [2:0] exp_g [4];
      logic [1:0] exp_p [4];
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
      exp_p = '{2'd0, 2'd1, 2'd2, 2'd0};
      do_reset();
      req3 = 3'b111; gnt_rdy3 = 1'b1; lock3 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (gnt3 !== exp_g[i] || ptr3 !== exp_p[i] || ptr3 === 2'd3) begin
            errors++;
            $display("FAIL three_seq[%0d]: gnt=%b ptr=%0d, want %b %0d", i, gnt3, ptr3, exp_g[i], exp_p[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b1111; gnt_rdy = 1'b0;
      @(negedge clk);
      gnt_rdy = 1'b1;
      @(negedge clk);
      gnt_rdy = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || ptr !== 2'd0) begin
         errors++;
         $display("FAIL async_reset: gnt=%b vld=%b ptr=%0d, want 0000 0 0", gnt, gnt_vld, ptr);
      end
      @(negedge clk);
      req = 4'b0010;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || ptr !== 2'd0) begin
         errors++;
         $display("FAIL post_reset: gnt=%b idx=%0d ptr=%0d, want 0010 1 0", gnt, gnt_idx, ptr);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req = '0; lock = 1'b0; gnt_rdy = 1'b0;
      req3 = '0; lock3 = 1'b0; gnt_rdy3 = 1'b0;
      test_reset();
      test_round_robin();
      test_hold();
      test_lock();
      test_three();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Registered round-robin arbiter that shares one downstream resource port among `NUM_REQ` requesters. It issues at most one one-hot grant at a time and holds it until the downstream handshake completes. A lock input extends a grant across multi-beat transfers. It sits in front of any shared resource, such as a memory port, CDB slot or functional unit, and carries its own one-hot SVA check on the grant vector.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `IDX_W`, default `$clog2(NUM_REQ)`: width of the encoded grant index.

Ports:
- `clk`, input, 1: single clock domain.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, NUM_REQ: per-requester request. Each bit is held until that requester's handshake.
- `lock`, input, 1: sampled on a handshake. If 1, the current owner keeps the grant for the next beat.
- `gnt`, output, NUM_REQ: one-hot grant, or all zero when idle.
- `gnt_idx`, output, IDX_W: binary index of the `gnt` bit. 0 when idle.
- `gnt_vld`, output, 1: equals `|gnt`.
- `gnt_rdy`, input, 1: downstream accept. A handshake is `gnt_vld & gnt_rdy`.
- `ptr`, output, IDX_W: current round-robin priority pointer, exposed for debug and coverage.

## Operation
- State machine with two states:
  - **IDLE**: no grant.
  - **BUSY**: grant held.
- IDLE → BUSY when `|req`. The winner is the first set `req` bit scanning upward from `ptr`, with wrap-around. The winner is registered into `gnt` and `gnt_idx`.
- BUSY with `gnt_rdy == 0`: `gnt` and `gnt_idx` are frozen, regardless of `req` changes. This includes the owner dropping `req`, which is a protocol violation but must not glitch the grant.
- BUSY with a handshake and `lock == 1`: the same owner stays granted and `ptr` is unchanged.
- BUSY with a handshake and `lock == 0`:
  - `ptr` ← (`gnt_idx` + 1) mod `NUM_REQ`.
  - The next winner is computed in the same cycle from `req` with the owner's bit masked off, scanning from the new `ptr`.
  - If there is a winner, stay in BUSY with the new grant. This gives back-to-back grants with no bubble.
  - Otherwise go to IDLE.
- The wrap of `ptr` past `NUM_REQ-1` goes to 0. This must be correct for non-power-of-two `NUM_REQ`.
- Fairness: with all requests held, each requester is granted once per `NUM_REQ` handshakes.

## Timing
- Reset values, applied asynchronously:
  - State = IDLE.
  - `gnt` = 0, `gnt_idx` = 0, `gnt_vld` = 0.
  - `ptr` = 0.
- Latency: `req` asserted at edge t appears as `gnt` after edge t+1. This is one registered stage, and all outputs are flops.
- A handshake at edge t gives the next grant visible after edge t+1. Sustained throughput is one grant per cycle when `gnt_rdy` is held high.
- `gnt_rdy` is allowed while idle and is ignored.
- Reset asserted mid-grant drops `gnt` immediately, without waiting for a clock edge. No pending state survives reset.

## Structure
- The state enum (`RR_IDLE`, `RR_BUSY`) goes in the shared arbiter package, alongside other arbitration typedefs.
- Natural sub-module: `rr_pick`, purely combinational. Inputs are the request vector and the pointer. Outputs are the one-hot winner and its index, implemented as a double-width masked priority scan.
- Embedded SVA checks, compiled out under the standard assertion-disable define:
  - `gnt` is one-hot or zero.
  - `gnt` is stable while `gnt_vld & ~gnt_rdy`.
  - `gnt_vld == |gnt`.

## Test plan
- Reset, then `req=4'b0000` → `gnt=0`, `ptr=0`. Then `req=4'b0100` → after one edge `gnt=4'b0100`, `gnt_idx=2`.
- `req=4'b1111` held, `gnt_rdy=1`, `lock=0` → `gnt` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with no idle bubble.
- `gnt=4'b0010` with `gnt_rdy=0` for 5 cycles while `req` changes to 4'b1101 → `gnt` stays 0010. Raise `gnt_rdy` → next `gnt=4'b0100`, `ptr=2`.
- `lock=1` for 3 handshakes from requester 3 with `req=4'b1001` → `gnt=4'b1000` for all 3 handshakes. Drop `lock` → next grant goes to requester 0, wrapping past 3 to 0.
- `NUM_REQ=3`, all requests held → grant order 0, 1, 2, 0, and `ptr` never reaches 3.
- Assert `rst_n=0` between clock edges during BUSY → `gnt` goes to 0 immediately. After release with `req=4'b0010`, the grant goes to requester 1 from `ptr=0`.
